// File: rtl/dragon_ram_arbiter_pkg.sv
// Shared definitions for the DragonRAM port-0 arbiter: FSM encodings and default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dragon_pkg;

    localparam int DRAGON_ADDR_WIDTH = 10;
    localparam int DRAGON_DATA_WIDTH = 36;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_READ  = 2'd2
    } arb_state_t;

    // Index width for a requester count; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dragon_ram_arbiter_rr_pick.sv
// Round-robin picker: first requester after the last winner, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module dragon_rr_pick
    import dragon_pkg::*;
#(
    parameter int N    = 2,
    parameter int IdxW = idx_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
`ifdef DRAGON_ARB_LOCK_EN
    input  logic [N-1:0]    mask,
`endif
    output logic [IdxW-1:0] winner,
    output logic            valid
);

    logic [N-1:0] cand;

`ifdef DRAGON_ARB_LOCK_EN
    assign cand = req & mask;
`else
    assign cand = req;
`endif

    // Scan from the slot after the last winner; the first candidate found wins.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!valid && cand[idx]) begin
                valid  = 1'b1;
                winner = idx[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/dragon_ram_arbiter.sv
// Shares DragonRAM port 0 between N requesters with round-robin accepts (optional lock: DRAGON_ARB_LOCK_EN).
// Latency: write commits at the edge after accept; read data/RValid follow two edges after accept.
// Backpressure: Req is held until a one-cycle Gnt; requests are ignored while an access is in flight.
module dragon_ram_arbiter
    import dragon_pkg::*;
#(
    parameter int NumRequesters = 2,
    parameter int AddrWidth     = DRAGON_ADDR_WIDTH,
    parameter int DataWidth     = DRAGON_DATA_WIDTH
) (
    input  logic                               Clock,
    input  logic                               Reset,
    input  logic [NumRequesters-1:0]           Req,
    input  logic [NumRequesters-1:0]           Write,
`ifdef DRAGON_ARB_LOCK_EN
    input  logic [NumRequesters-1:0]           Lock,
`endif
    input  logic [NumRequesters*AddrWidth-1:0] Addr,
    input  logic [NumRequesters*DataWidth-1:0] WData,
    output logic [NumRequesters-1:0]           Gnt,
    output logic [NumRequesters-1:0]           RValid,
    output logic [DataWidth-1:0]               RData,
    output logic                               Busy,
    output logic                               MemWriteEnable,
    output logic [AddrWidth-1:0]               MemAddress,
    output logic [DataWidth-1:0]               MemDataWrite,
    input  logic [DataWidth-1:0]               MemDataRead
);

    localparam int IdxW = idx_width(NumRequesters);

    arb_state_t                 state, state_n;
    logic [IdxW-1:0]            ptr, ptr_n;
    logic [IdxW-1:0]            win, win_n;
    logic                       wr_lat, wr_n;
    logic [NumRequesters-1:0]   gnt_n, rvalid_n;
    logic [DataWidth-1:0]       rdata_n, mwdat_n;
    logic [AddrWidth-1:0]       maddr_n;
    logic                       we_n;
    logic [IdxW-1:0]            pick_w;
    logic                       pick_vld;

`ifdef DRAGON_ARB_LOCK_EN
    logic                       locked, locked_n;
    logic [NumRequesters-1:0]   lock_mask;

    // While locked only the owner (which is also the pointer) may be picked.
    assign lock_mask = locked ? ({{(NumRequesters-1){1'b0}}, 1'b1} << ptr) : '1;
`endif

    dragon_rr_pick #(
        .N    (NumRequesters),
        .IdxW (IdxW)
    ) u_pick (
        .req    (Req),
        .ptr    (ptr),
`ifdef DRAGON_ARB_LOCK_EN
        .mask   (lock_mask),
`endif
        .winner (pick_w),
        .valid  (pick_vld)
    );

    assign Busy = (state != ARB_IDLE);

    // Next-state and next-output logic; pulses default low, data registers hold.
    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        win_n    = win;
        wr_n     = wr_lat;
        gnt_n    = '0;
        rvalid_n = '0;
        rdata_n  = RData;
        we_n     = 1'b0;
        maddr_n  = MemAddress;
        mwdat_n  = MemDataWrite;
`ifdef DRAGON_ARB_LOCK_EN
        locked_n = locked;
`endif
        case (state)
            ARB_IDLE: begin
                if (pick_vld) begin
                    gnt_n[pick_w] = 1'b1;
                    ptr_n         = pick_w;
                    win_n         = pick_w;
                    wr_n          = Write[pick_w];
                    we_n          = Write[pick_w];
                    maddr_n       = Addr[int'(pick_w)*AddrWidth +: AddrWidth];
                    mwdat_n       = WData[int'(pick_w)*DataWidth +: DataWidth];
                    state_n       = ARB_ISSUE;
                end
`ifdef DRAGON_ARB_LOCK_EN
                // Lock is (re)armed by a locked accept and released by any other IDLE cycle.
                locked_n = pick_vld && Lock[pick_w];
`endif
            end
            ARB_ISSUE: begin
                state_n = wr_lat ? ARB_IDLE : ARB_READ;
            end
            ARB_READ: begin
                rdata_n       = MemDataRead;
                rvalid_n[win] = 1'b1;
                state_n       = ARB_IDLE;
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset parks the pointer so requester 0 wins first.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state          <= ARB_IDLE;
            ptr            <= IdxW'(NumRequesters - 1);
            win            <= '0;
            wr_lat         <= 1'b0;
            Gnt            <= '0;
            RValid         <= '0;
            RData          <= '0;
            MemWriteEnable <= 1'b0;
            MemAddress     <= '0;
            MemDataWrite   <= '0;
`ifdef DRAGON_ARB_LOCK_EN
            locked         <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            ptr            <= ptr_n;
            win            <= win_n;
            wr_lat         <= wr_n;
            Gnt            <= gnt_n;
            RValid         <= rvalid_n;
            RData          <= rdata_n;
            MemWriteEnable <= we_n;
            MemAddress     <= maddr_n;
            MemDataWrite   <= mwdat_n;
`ifdef DRAGON_ARB_LOCK_EN
            locked         <= locked_n;
`endif
        end
    end

endmodule

// File: doc/dragon_ram_arbiter.md
Name: dragon_ram_arbiter

Overview:
- Shares one DragonRAM port (port 0: address, write data, write enable, registered read) between N requesters, e.g. the core data path, a program loader and a debug port.
- Round-robin arbitration with a registered req/grant handshake and a fixed 3-edge read latency.
- Sits between the requesters and DragonRAM. Port 1 stays dedicated to instruction fetch.

Parameters:
- NumRequesters, 2, number of requesters N (2..8).
- AddrWidth, 10, RAM address width.
- DataWidth, 36, RAM word width.

Ports:
- Clock  input  1  single clock, rising edge.
- Reset  input  1  asynchronous, active-high.
- Req  input  N  request per requester; held until Gnt is seen.
- Write  input  N  1 = write, 0 = read; qualified by Req.
- Addr  input  N*AddrWidth  request addresses; requester i uses slice [i*AddrWidth +: AddrWidth].
- WData  input  N*DataWidth  write data, sliced the same way.
- Gnt  output  N  one-cycle registered accept pulse, one-hot.
- RValid  output  N  one-cycle read-data-valid pulse, one-hot.
- RData  output  DataWidth  read data, shared; meaningful only while an RValid bit is high.
- Busy  output  1  high while state is not IDLE.
- MemWriteEnable  output  1  drives RAM WriteEnable0.
- MemAddress  output  AddrWidth  drives RAM Address0.
- MemDataWrite  output  DataWidth  drives RAM Data0Write.
- MemDataRead  input  DataWidth  from RAM Data0Read.

Behaviour:
- Reset (async, immediate), all outputs:
  - Gnt = 0, RValid = 0, RData = 0, Busy = 0.
  - MemWriteEnable = 0, MemAddress = 0, MemDataWrite = 0.
  - state = IDLE, last-winner pointer = N-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, READ.
- IDLE:
  - If any Req bit is high, pick the winner w. Search starts at pointer+1 and wraps modulo N.
  - Register MemAddress = Addr[w] and MemDataWrite = WData[w]; MemWriteEnable = Write[w].
  - Gnt[w] = 1, pointer = w, latch Write[w] and w, go to ISSUE.
  - If no Req is high, stay in IDLE.
- ISSUE:
  - The RAM samples the Mem* outputs on this edge.
  - At the edge: MemWriteEnable = 0 and Gnt = 0.
  - Latched write: go to IDLE. Latched read: go to READ.
  - Requests are never sampled in ISSUE, so a Req still held after Gnt cannot be double-accepted.
- READ:
  - MemDataRead is valid (RAM registered output).
  - At the edge: RData = MemDataRead, RValid[w] = 1 for one cycle, go to IDLE.
  - The RValid pulse is seen together with IDLE. A new accept at the following edge clears it.
- Timing, counted from accept edge E0:
  - Write occupies 2 edges and commits to RAM at E1.
  - Read returns RValid/RData after E2.
  - Peak throughput is 1 read per 3 cycles, 1 write per 2.
- A requester may drop Req, or present a new request, in the cycle after Gnt.
- Req dropped before Gnt: the request is simply not served. Nothing is latched.
- Simultaneous requests: the round-robin order gives each requester at most one access per N accesses.
- Read-after-write to the same address by different requesters: served in grant order, so the read returns the new data.
- Reset during ISSUE or READ: the access is abandoned and no RValid is issued. A write in ISSUE may or may not have committed (undefined).
- Address and data slices are passed unmodified; no width conversion.

Optional Feature:
- Macro: DRAGON_ARB_LOCK_EN.
- With the macro defined:
  - Extra input Lock [N], qualified by Req.
  - If the IDLE winner w has Lock[w] high, the arbiter enters a locked mode.
  - In locked mode, subsequent IDLE cycles consider only requester w, and the pointer does not advance.
  - The lock releases at the first IDLE cycle where Lock[w] is low or Req[w] is low.
  - This gives atomic read-modify-write sequences for STORE/LOAD pairs.
  - Reset clears the lock.
- Without the macro: no Lock port; pure round-robin.

Decomposition:
- Shared package dragon_pkg:
  - State encodings ARB_IDLE = 2'd0, ARB_ISSUE = 2'd1, ARB_READ = 2'd2.
  - Default widths DRAGON_ADDR_WIDTH = 10, DRAGON_DATA_WIDTH = 36.
- One sub-module: dragon_rr_pick.
  - Combinational round-robin priority picker.
  - Inputs: request vector and pointer (plus a mask when the lock feature is enabled).
  - Outputs: winner index and a valid flag.

Test Plan:
- Single read: after reset, RAM[5] = 36'h123456789; Req0 read Addr 5. Expect Gnt0 after E0, MemAddress = 5, RValid0 after E2, RData = 36'h123456789.
- Write then read: Req1 writes 36'hABC to Addr 7, then reads Addr 7. Expect MemWriteEnable high exactly one cycle; read returns 36'hABC.
- Contention: Req0 and Req1 both held for 4 accesses. Expect grant order 0, 1, 0, 1 and never two Gnt bits high together.
- Held Req: Req0 kept high for 6 cycles as one logical read. Expect one Gnt at E0, none at E1, then a second grant at E3 (re-request).
- Reset mid-read: assert Reset in READ. Expect all outputs 0 immediately, no RValid, and the first grant after release goes to requester 0.
- Lock (with DRAGON_ARB_LOCK_EN): Req0 with Lock0 performs read then write of Addr 3 while Req1 is pending. Expect Req1 granted only after Lock0 drops.
